amstrad_audio_mixer: RTL and testbench
======================================

Name: amstrad_audio_mixer

Overview:
- Parametrised, time-multiplexed stereo mixer for PSG-style tone channels.
- Generalises the fixed three-channel A/B/C-to-L/R combine to NCH channels with per-channel 3-bit left/right gains and selectable mix modes.
- Processes one channel per clock after a sample strobe, then presents saturated, registered outputs with a valid pulse.
- Sits between the PSG (or PSG plus expansion sound sources) and the board audio outputs.

Parameters:
- NCH, 3, number of input channels (1..8).
- IW, 8, bits per unsigned channel sample.
- OW, 8, bits per output sample.
- SHIFT, 3, right-shift applied to each accumulator before saturation.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  sample strobe; starts one mix pass.
- ch_in  in  NCH*IW  channel samples, unsigned; channel k occupies bits [k*IW +: IW].
- gain_l  in  NCH*3  left gain per channel, 0..7; channel k occupies bits [k*3 +: 3].
- gain_r  in  NCH*3  right gain per channel, 0..7; same packing as gain_l.
- mode  in  2  mix mode: 0 = per-channel gains, 1 = mono, 2 = legacy ABC, 3 = same as 0.
- mute  in  1  forces both outputs to zero on the next result.
- out_l  out  OW  left sample, registered.
- out_r  out  OW  right sample, registered.
- valid  out  1  one-cycle pulse when out_l/out_r update.
- busy  out  1  high while a pass is in progress.
- overrun  out  1  sticky; set when ce arrives while busy.

Behaviour:
- Reset: out_l=0, out_r=0, valid=0, busy=0, overrun=0, accumulators=0, state=IDLE. Reset overrides every other input, including ce and an active pass.
- States: IDLE, ACC, DONE.
- IDLE:
  - On ce=1: snapshot ch_in, the effective gains and mute into internal registers.
  - Clear both accumulators, set channel index=0, busy=1, go to ACC.
- Effective gain selection, decided at snapshot:
  - mode 0/3: gain_l, gain_r as supplied.
  - mode 1: all channels L=2, R=2.
  - mode 2: ch0 L=4 R=0; ch1 L=2 R=2; ch2 L=0 R=4; channels 3 and above L=0 R=0.
- ACC: each cycle:
  - acc_l += snap_ch[idx]*gl[idx]; acc_r += snap_ch[idx]*gr[idx]; idx++.
  - After idx=NCH-1 has been added, go to DONE.
  - Accumulator width is IW+3+clog2(NCH+1), so no internal overflow is possible.
- DONE: one cycle.
  - out_x = min((acc_x >> SHIFT), 2^OW-1), or 0 if the snapshot mute is set.
  - valid=1 for this cycle only; busy=0; return to IDLE.
- Latency: ce at cycle T gives valid at cycle T+NCH+1. Outputs are stable from then until the next valid.
- Outputs hold their last values between passes. valid is 0 except in the DONE cycle.
- ce while busy (ACC or DONE): ignored, no restart, overrun:=1. Only reset clears overrun.
- ce in the IDLE cycle immediately after DONE is accepted normally (back-to-back passes are allowed).
- Input changes after the snapshot do not affect the pass in progress.
- Reset mid-pass: the pass is abandoned. No valid pulse is produced. Outputs read 0.

Test Plan:
- Reset state: assert reset 2 cycles with ce=1 -> out_l=out_r=0, valid=busy=overrun=0. No valid pulse follows release until a new ce.
- Legacy mode (defaults, mode=2): ch0=200, ch1=100, ch2=40, ce pulse -> valid exactly 4 cycles later. out_l=(800+200)>>3=125. out_r=(200+160)>>3=45.
- Saturation (mode=0): all channels 255, all gains 7 -> acc=5355, >>3 = 669 -> out_l=out_r=255.
- Mono mode with mute: mode=1, mute=1, nonzero inputs -> valid pulses, outputs 0. Next pass with mute=0 and ch=8,8,8 -> out=(48)>>3=6 on both sides.
- Overrun and snapshot:
  - Second ce one cycle after the first -> overrun=1 and only one valid pulse.
  - Changing ch_in mid-pass does not alter the result.
  - overrun stays 1 until reset.
- Reset mid-pass, and NCH=8 / OW=10 instance:
  - Reset during ACC -> no valid pulse, outputs 0.
  - On the NCH=8, OW=10 instance, ce -> valid at T+9. 8 channels of 255 with gain 7 and SHIFT=3 -> 14280>>3=1785 -> saturates to 1023.

Source files
------------

// File: rtl/amstrad_audio_mixer.sv
// ---------------------------------------------------------------------------
// amstrad_audio_mixer
//   Time-multiplexed stereo mixer for PSG-style tone channels. Each ce strobe
//   captures the channel samples, the effective gains and the mute flag. The
//   mixer then adds one channel per clock into a left and a right accumulator.
//   It finishes by presenting shifted, saturated, registered outputs together
//   with a one-cycle valid pulse.
//
// Parameters
//   NCH   number of input channels (1..8)
//   IW    bits per unsigned channel sample
//   OW    bits per output sample
//   SHIFT right shift applied to each accumulator before saturation
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   ce       sample strobe, starts one mix pass when idle
//   ch_in    packed channel samples, channel k at [k*IW +: IW]
//   gain_l   packed 3-bit left gains, channel k at [k*3 +: 3]
//   gain_r   packed 3-bit right gains, same packing as gain_l
//   mode     0/3 per-channel gains, 1 mono, 2 legacy ABC
//   mute     zeroes both outputs of the pass it is captured with
//   out_l    registered left sample
//   out_r    registered right sample
//   valid    one-cycle pulse when out_l/out_r update
//   busy     high while a pass is in progress (ACC and DONE)
//   overrun  sticky, set by ce while busy, cleared only by reset
// ---------------------------------------------------------------------------
module amstrad_audio_mixer #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned IW    = 8,
    parameter int unsigned OW    = 8,
    parameter int unsigned SHIFT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [NCH*IW-1:0] ch_in,
    input  logic [NCH*3-1:0]  gain_l,
    input  logic [NCH*3-1:0]  gain_r,
    input  logic [1:0]        mode,
    input  logic              mute,
    output logic [OW-1:0]     out_l,
    output logic [OW-1:0]     out_r,
    output logic              valid,
    output logic              busy,
    output logic              overrun
);

    // The accumulator is wide enough for NCH full-scale products, so it can never wrap.
    localparam int unsigned PW = IW + 3;
    localparam int unsigned AW = IW + 3 + $clog2(NCH + 1);
    localparam int unsigned XW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = (AW > OW) ? AW : OW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     snap_ch_q [NCH];
    logic [2:0]        snap_gl_q [NCH];
    logic [2:0]        snap_gr_q [NCH];
    logic              snap_mute_q;
    logic [XW-1:0]     idx_q;
    logic [AW-1:0]     acc_l_q;
    logic [AW-1:0]     acc_r_q;
    logic [OW-1:0]     out_l_q;
    logic [OW-1:0]     out_r_q;
    logic              valid_q;
    logic              busy_q;
    logic              overrun_q;

    logic [2:0]        eff_gl [NCH];
    logic [2:0]        eff_gr [NCH];
    logic [PW-1:0]     prod_l;
    logic [PW-1:0]     prod_r;
    logic [AW-1:0]     acc_l_d;
    logic [AW-1:0]     acc_r_d;
    logic [OW-1:0]     out_l_d;
    logic [OW-1:0]     out_r_d;
    logic              last_ch;

    // The mode is resolved into per-channel gains here, so the snapshot stores the final gains.
    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            eff_gl[k] = gain_l[k*3 +: 3];
            eff_gr[k] = gain_r[k*3 +: 3];
            case (mode)
                2'd1: begin
                    eff_gl[k] = 3'd2;
                    eff_gr[k] = 3'd2;
                end
                2'd2: begin
                    eff_gl[k] = 3'd0;
                    eff_gr[k] = 3'd0;
                    if (k == 0) begin
                        eff_gl[k] = 3'd4;
                    end else if (k == 1) begin
                        eff_gl[k] = 3'd2;
                        eff_gr[k] = 3'd2;
                    end else if (k == 2) begin
                        eff_gr[k] = 3'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [OW-1:0] saturate(input logic [AW-1:0] a);
        logic [CW-1:0] s;
        s = CW'(a >> SHIFT);
        if (s > CW'((64'd1 << OW) - 64'd1)) begin
            return '1;
        end
        return OW'(s);
    endfunction

    // The final accumulator value (including the last channel) feeds the output
    // registers directly, so the result lands on the same edge that enters DONE.
    always_comb begin
        prod_l  = PW'(snap_ch_q[idx_q]) * PW'(snap_gl_q[idx_q]);
        prod_r  = PW'(snap_ch_q[idx_q]) * PW'(snap_gr_q[idx_q]);
        acc_l_d = acc_l_q + AW'(prod_l);
        acc_r_d = acc_r_q + AW'(prod_r);
        out_l_d = snap_mute_q ? '0 : saturate(acc_l_d);
        out_r_d = snap_mute_q ? '0 : saturate(acc_r_d);
        last_ch = (idx_q == XW'(NCH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            snap_mute_q <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
                snap_ch_q[k] <= '0;
                snap_gl_q[k] <= '0;
                snap_gr_q[k] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ce) begin
                        for (int unsigned k = 0; k < NCH; k++) begin
                            snap_ch_q[k] <= ch_in[k*IW +: IW];
                            snap_gl_q[k] <= eff_gl[k];
                            snap_gr_q[k] <= eff_gr[k];
                        end
                        snap_mute_q <= mute;
                        acc_l_q     <= '0;
                        acc_r_q     <= '0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (ce) begin
                        overrun_q <= 1'b1;
                    end
                    acc_l_q <= acc_l_d;
                    acc_r_q <= acc_r_d;
                    if (last_ch) begin
                        out_l_q <= out_l_d;
                        out_r_q <= out_r_d;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ce) begin
                        overrun_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_l   = out_l_q;
    assign out_r   = out_r_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_amstrad_audio_mixer.sv
module tb_amstrad_audio_mixer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults (NCH=3, OW=8)
    logic        ce_a = 1'b0;
    logic [23:0] ch_a = '0;
    logic [8:0]  gl_a = '0;
    logic [8:0]  gr_a = '0;
    logic [1:0]  mode_a = 2'd0;
    logic        mute_a = 1'b0;
    logic [7:0]  outl_a, outr_a;
    logic        valid_a, busy_a, ovr_a;

    // Instance B: NCH=8, OW=10
    logic        ce_b = 1'b0;
    logic [63:0] ch_b = '0;
    logic [23:0] gl_b = '0;
    logic [23:0] gr_b = '0;
    logic [1:0]  mode_b = 2'd0;
    logic        mute_b = 1'b0;
    logic [9:0]  outl_b, outr_b;
    logic        valid_b, busy_b, ovr_b;

    amstrad_audio_mixer u_a (
        .clk(clk), .reset(rst), .ce(ce_a), .ch_in(ch_a), .gain_l(gl_a), .gain_r(gr_a),
        .mode(mode_a), .mute(mute_a), .out_l(outl_a), .out_r(outr_a),
        .valid(valid_a), .busy(busy_a), .overrun(ovr_a)
    );

    amstrad_audio_mixer #(.NCH(8), .IW(8), .OW(10), .SHIFT(3)) u_b (
        .clk(clk), .reset(rst), .ce(ce_b), .ch_in(ch_b), .gain_l(gl_b), .gain_r(gr_b),
        .mode(mode_b), .mute(mute_b), .out_l(outl_b), .out_r(outr_b),
        .valid(valid_b), .busy(busy_b), .overrun(ovr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: sum of sample*gain over channels, shifted, clamped to full scale.
    function automatic void model(input int n, input int ch[8], input int gl[8], input int gr[8],
                                  input int md, input int mt, input int sh, input int ow,
                                  output int l, output int r);
        longint sl = 0;
        longint sr = 0;
        longint full = (longint'(1) << ow) - 1;
        for (int k = 0; k < n; k++) begin
            int el = gl[k];
            int er = gr[k];
            if (md == 1) begin
                el = 2; er = 2;
            end else if (md == 2) begin
                el = (k == 0) ? 4 : (k == 1) ? 2 : 0;
                er = (k == 2) ? 4 : (k == 1) ? 2 : 0;
            end
            sl += longint'(ch[k]) * el;
            sr += longint'(ch[k]) * er;
        end
        sl = sl >> sh;
        sr = sr >> sh;
        l = (mt != 0) ? 0 : int'((sl > full) ? full : sl);
        r = (mt != 0) ? 0 : int'((sr > full) ? full : sr);
    endfunction

    // Called at a negedge; returns at the negedge after the valid cycle (IDLE).
    // Inputs are scrambled right after the strobe to show the snapshot holds.
    task automatic run_a(input int ch[8], input int gl[8], input int gr[8], input int md,
                         input int mt, input int el, input int er, input string tag);
        int lat;
        bit seen;
        for (int k = 0; k < 3; k++) begin
            ch_a[k*8 +: 8] = 8'(ch[k]);
            gl_a[k*3 +: 3] = 3'(gl[k]);
            gr_a[k*3 +: 3] = 3'(gr[k]);
        end
        mode_a = 2'(md);
        mute_a = 1'(mt);
        ce_a = 1'b1;
        @(negedge clk);
        ce_a = 1'b0;
        ch_a = 24'($urandom);
        gl_a = 9'($urandom);
        gr_a = 9'($urandom);
        mode_a = 2'($urandom);
        mute_a = 1'($urandom);
        lat = 1;
        seen = 0;
        while (!seen && lat < 20) begin
            if (valid_a) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, " latency"}, seen ? lat : -1, 4);
        check({tag, " out_l"}, outl_a, el);
        check({tag, " out_r"}, outr_a, er);
        @(negedge clk);
        check({tag, " valid one cycle"}, valid_a, 0);
        check({tag, " busy after"}, busy_a, 0);
        check({tag, " out_l hold"}, outl_a, el);
    endtask

    task automatic run_b(input int ch[8], input int gl[8], input int gr[8], input int md,
                         input string tag);
        int el, er, lat;
        bit seen;
        model(8, ch, gl, gr, md, 0, 3, 10, el, er);
        for (int k = 0; k < 8; k++) begin
            ch_b[k*8 +: 8] = 8'(ch[k]);
            gl_b[k*3 +: 3] = 3'(gl[k]);
            gr_b[k*3 +: 3] = 3'(gr[k]);
        end
        mode_b = 2'(md);
        mute_b = 1'b0;
        ce_b = 1'b1;
        @(negedge clk);
        ce_b = 1'b0;
        ch_b = {$urandom, $urandom};
        lat = 1;
        seen = 0;
        while (!seen && lat < 30) begin
            if (valid_b) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, " latency"}, seen ? lat : -1, 9);
        check({tag, " out_l"}, outl_b, el);
        check({tag, " out_r"}, outr_b, er);
        @(negedge clk);
        check({tag, " valid one cycle"}, valid_b, 0);
    endtask

    typedef struct {
        int ch[8];
        int gl[8];
        int gr[8];
        int md;
        int mt;
        int el;
        int er;
        string name;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int pulses;
        int ch[8], gl[8], gr[8];
        int el, er;

        tbl[0].ch = '{200, 100, 40, 0, 0, 0, 0, 0}; tbl[0].gl = '{7, 7, 7, 0, 0, 0, 0, 0};
        tbl[0].gr = '{7, 7, 7, 0, 0, 0, 0, 0};       tbl[0].md = 2; tbl[0].mt = 0;
        tbl[0].el = 125; tbl[0].er = 45;              tbl[0].name = "legacy";
        tbl[1].ch = '{255, 255, 255, 0, 0, 0, 0, 0}; tbl[1].gl = '{7, 7, 7, 0, 0, 0, 0, 0};
        tbl[1].gr = '{7, 7, 7, 0, 0, 0, 0, 0};       tbl[1].md = 0; tbl[1].mt = 0;
        tbl[1].el = 255; tbl[1].er = 255;             tbl[1].name = "saturate";
        tbl[2].ch = '{50, 60, 70, 0, 0, 0, 0, 0};    tbl[2].gl = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[2].gr = '{1, 1, 1, 0, 0, 0, 0, 0};       tbl[2].md = 1; tbl[2].mt = 1;
        tbl[2].el = 0; tbl[2].er = 0;                 tbl[2].name = "mono_mute";
        tbl[3].ch = '{8, 8, 8, 0, 0, 0, 0, 0};       tbl[3].gl = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].gr = '{0, 0, 0, 0, 0, 0, 0, 0};       tbl[3].md = 1; tbl[3].mt = 0;
        tbl[3].el = 6; tbl[3].er = 6;                 tbl[3].name = "mono";
        tbl[4].ch = '{10, 20, 30, 0, 0, 0, 0, 0};    tbl[4].gl = '{1, 2, 3, 0, 0, 0, 0, 0};
        tbl[4].gr = '{3, 2, 1, 0, 0, 0, 0, 0};       tbl[4].md = 3; tbl[4].mt = 0;
        tbl[4].el = 17; tbl[4].er = 12;               tbl[4].name = "mode3";
        tbl[5].ch = '{255, 0, 0, 0, 0, 0, 0, 0};     tbl[5].gl = '{7, 0, 0, 0, 0, 0, 0, 0};
        tbl[5].gr = '{0, 0, 1, 0, 0, 0, 0, 0};       tbl[5].md = 0; tbl[5].mt = 0;
        tbl[5].el = 223; tbl[5].er = 0;               tbl[5].name = "per_channel";

        // Reset held with ce asserted
        rst = 1'b1;
        ce_a = 1'b1;
        ce_b = 1'b1;
        ch_a = '1;
        gl_a = '1;
        gr_a = '1;
        repeat (2) @(negedge clk);
        check("reset out_l", outl_a, 0);
        check("reset out_r", outr_a, 0);
        check("reset valid", valid_a, 0);
        check("reset busy", busy_a, 0);
        check("reset overrun", ovr_a, 0);
        check("reset b busy", busy_b, 0);
        rst = 1'b0;
        ce_a = 1'b0;
        ce_b = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_a) pulses++;
        end
        check("no valid after reset", pulses, 0);

        // Table vectors, issued back-to-back
        for (int i = 0; i < 6; i++) begin
            run_a(tbl[i].ch, tbl[i].gl, tbl[i].gr, tbl[i].md, tbl[i].mt, tbl[i].el, tbl[i].er,
                  tbl[i].name);
        end

        // Random passes against the model
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < 8; k++) begin
                ch[k] = int'($urandom_range(255));
                gl[k] = int'($urandom_range(7));
                gr[k] = int'($urandom_range(7));
            end
            model(3, ch, gl, gr, int'($urandom_range(3)), 0, 3, 8, el, er);
            begin
                int md = int'($urandom_range(3));
                int mt = int'($urandom_range(3) == 0);
                model(3, ch, gl, gr, md, mt, 3, 8, el, er);
                run_a(ch, gl, gr, md, mt, el, er, $sformatf("rand%0d", i));
            end
        end
        check("no overrun yet", ovr_a, 0);

        // Second ce one cycle after the first: ignored, single pulse, overrun set
        for (int k = 0; k < 3; k++) ch_a[k*8 +: 8] = 8'd16;
        mode_a = 2'd1;
        mute_a = 1'b0;
        ce_a = 1'b1;
        @(negedge clk);
        ch_a = '1;
        @(negedge clk);
        ce_a = 1'b0;
        pulses = 0;
        el = -1;
        repeat (12) begin
            if (valid_a) begin
                pulses++;
                el = int'(outl_a);
            end
            @(negedge clk);
        end
        check("overrun single pulse", pulses, 1);
        check("overrun result", el, 12);
        check("overrun set", ovr_a, 1);
        run_a(tbl[3].ch, tbl[3].gl, tbl[3].gr, 1, 0, 6, 6, "after_overrun");
        check("overrun sticky", ovr_a, 1);

        // Reset during ACC abandons the pass
        ch_a = {8'd40, 8'd100, 8'd200};
        mode_a = 2'd2;
        ce_a = 1'b1;
        @(negedge clk);
        ce_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            if (valid_a) pulses++;
            @(negedge clk);
        end
        check("midpass no valid", pulses, 0);
        check("midpass out_l", outl_a, 0);
        check("midpass out_r", outr_a, 0);
        check("midpass busy", busy_a, 0);
        check("midpass overrun cleared", ovr_a, 0);

        // Wide instance: saturation at 10 bits, then model-checked passes
        for (int k = 0; k < 8; k++) begin
            ch[k] = 255; gl[k] = 7; gr[k] = 7;
        end
        run_b(ch, gl, gr, 0, "b_saturate");
        check("b_saturate value", outl_b, 1023);
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) begin
                ch[k] = int'($urandom_range(255));
                gl[k] = int'($urandom_range(7));
                gr[k] = int'($urandom_range(7));
            end
            run_b(ch, gl, gr, int'($urandom_range(3)), $sformatf("b_rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
